// File: rtl/i2s_audio_tx_pkg.sv
// Shared defaults for the I2S transmitter: sample width, 28 MHz BCLK divider and frame length.
package i2s_audio_tx_pkg;
  localparam int SAMPLE_W_DEF  = 16;
  localparam int BCLK_HALF_DEF = 9;   // 28 MHz / 18 = 1.556 MHz BCLK, 48.6 kHz fs
  localparam int FRAME_LEN_DEF = 2 * SAMPLE_W_DEF;
endpackage

// File: rtl/i2s_audio_tx_bclk_gen.sv
// BCLK prescaler: toggles bclk every BCLK_HALF enabled cycles and flags the cycle where bclk falls.
module i2s_bclk_gen
  import i2s_audio_tx_pkg::*;
#(
  parameter int BCLK_HALF = BCLK_HALF_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic bclk_o,
  output logic fall_o
);
  localparam int CNT_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCLK_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             tc;

  always_comb begin
    tc     = (cnt_q == CNT_MAX);
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    if (!en_i) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (tc) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Asserted during the cycle whose closing edge drives bclk 1->0.
  assign fall_o = en_i && tc && bclk_q;
  assign bclk_o = bclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end
endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S master transmitter: double-buffered 16-bit stereo pairs, one pair per 2*SAMPLE_W-slot frame.
// Build option I2S_TX_UNDERRUN_MUTE_EN: an underrun frame sends silence instead of repeating the last pair.
module i2s_audio_tx
  import i2s_audio_tx_pkg::*;
#(
  parameter int BCLK_HALF = BCLK_HALF_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] left,
  input  logic signed [SAMPLE_W-1:0] right,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       i2s_bclk,
  output logic                       i2s_ws,
  output logic                       i2s_data,
  output logic                       frame_strobe,
  output logic                       underrun
);
  localparam int FRAME_LEN = 2 * SAMPLE_W;
  localparam int SLOT_W    = $clog2(FRAME_LEN);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(FRAME_LEN - 1);
  localparam logic [SLOT_W-1:0] RIGHT_SLOT = SLOT_W'(SAMPLE_W);
  localparam logic [SLOT_W-1:0] LOAD_SLOT  = SLOT_W'(1);

  logic                 fall;
  logic [FRAME_LEN-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [FRAME_LEN-1:0] prev_q, prev_d;
  logic [FRAME_LEN-1:0] sh_q, sh_d;
  logic [SLOT_W-1:0]    slot_q, slot_d, slot_nx;
  logic                 ws_q, ws_d;
  logic                 data_q, data_d;
  logic                 strobe_q, strobe_d;
  logic                 under_q, under_d;
  logic [FRAME_LEN-1:0] src;

  i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en),
    .bclk_o(i2s_bclk),
    .fall_o(fall)
  );

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    prev_d      = prev_q;
    sh_d        = sh_q;
    slot_d      = slot_q;
    ws_d        = ws_q;
    data_d      = data_q;
    strobe_d    = 1'b0;
    under_d     = 1'b0;
    slot_nx     = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    src = hold_full_q ? hold_q : '0;
`else
    src = hold_full_q ? hold_q : prev_q;
`endif

    // Handshake stays live while disabled so one pair can be queued.
    if (sample_valid && !hold_full_q) begin
      hold_d      = {left, right};
      hold_full_d = 1'b1;
    end

    if (!en) begin
      slot_d = LAST_SLOT;
      ws_d   = 1'b0;
      data_d = 1'b0;
    end else if (fall) begin
      slot_d = slot_nx;
      ws_d   = (slot_nx >= RIGHT_SLOT);
      if (slot_nx == LOAD_SLOT) begin
        // Slot 1 carries the left MSB; slot 0 of the next frame carries the right LSB.
        data_d   = src[FRAME_LEN-1];
        sh_d     = {src[FRAME_LEN-2:0], 1'b0};
        prev_d   = src;
        strobe_d = 1'b1;
        under_d  = !hold_full_q;
        if (hold_full_q) hold_full_d = 1'b0;
      end else begin
        data_d = sh_q[FRAME_LEN-1];
        sh_d   = {sh_q[FRAME_LEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      prev_q      <= '0;
      sh_q        <= '0;
      slot_q      <= LAST_SLOT;
      ws_q        <= 1'b0;
      data_q      <= 1'b0;
      strobe_q    <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      prev_q      <= prev_d;
      sh_q        <= sh_d;
      slot_q      <= slot_d;
      ws_q        <= ws_d;
      data_q      <= data_d;
      strobe_q    <= strobe_d;
      under_q     <= under_d;
    end
  end

  assign sample_ready = ~hold_full_q;
  assign i2s_ws       = ws_q;
  assign i2s_data     = data_q;
  assign frame_strobe = strobe_q;
  assign underrun     = under_q;
endmodule

// File: tb/tb_i2s_audio_tx.sv
// Directed bench for i2s_audio_tx: frame format, handshake, underrun, enable/reset behaviour, BCLK/frame timing.
module tb_i2s_audio_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, en, sample_valid;
  logic signed [15:0] left, right;
  logic               sample_ready, i2s_bclk, i2s_ws, i2s_data, frame_strobe, underrun;

  logic               en9;
  logic signed [15:0] zero16 = '0;
  logic               valid9 = 1'b0;
  logic               ready9, bclk9, ws9, data9, strobe9, under9;

  i2s_audio_tx #(.BCLK_HALF(2), .SAMPLE_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .left(left), .right(right),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .i2s_bclk(i2s_bclk), .i2s_ws(i2s_ws), .i2s_data(i2s_data),
    .frame_strobe(frame_strobe), .underrun(underrun)
  );

  i2s_audio_tx #(.BCLK_HALF(9), .SAMPLE_W(16)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .en(en9), .left(zero16), .right(zero16),
    .sample_valid(valid9), .sample_ready(ready9),
    .i2s_bclk(bclk9), .i2s_ws(ws9), .i2s_data(data9),
    .frame_strobe(strobe9), .underrun(under9)
  );

`ifdef I2S_TX_UNDERRUN_MUTE_EN
  localparam logic [31:0] F2_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] F2_EXP = 32'hA5C3_0F01;
`endif

  int          checks = 0;
  int          fails  = 0;
  logic [31:0] tbl[$];
  int          idx = 0;
  bit          pend = 1'b0;
  int          accepts = 0;
  int          ready_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_src();
    idx = 0;
    {left, right} = tbl[0];
    sample_valid = 1'b1;
  endtask

  // One clk cycle; advances the source table after each accepted pair.
  task automatic tick();
    pend = sample_valid && sample_ready;
    @(negedge clk);
    if (pend) begin
      accepts++;
      if (sample_ready !== 1'b0) ready_bad++;
      idx++;
      if (idx < tbl.size()) {left, right} = tbl[idx];
      else sample_valid = 1'b0;
    end
  endtask

  task automatic next_fall();
    logic prev;
    bit   ok;
    prev = i2s_bclk;
    ok   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (prev && !i2s_bclk) begin
        ok = 1'b1;
        break;
      end
      prev = i2s_bclk;
    end
    if (!ok) chk("fall_timeout", {31'b0, ok}, 32'd1);
  endtask

  // Captures slots 1..32 (the last being slot 0 of the next frame), MSB first.
  task automatic capture_frame(output logic [31:0] dw, output logic [31:0] ww,
                               output int ns, output int nu, output int nr);
    dw = '0; ww = '0; ns = 0; nu = 0; nr = 0;
    for (int i = 0; i < 32; i++) begin
      next_fall();
      dw = {dw[30:0], i2s_data};
      ww = {ww[30:0], i2s_ws};
      if (frame_strobe) begin
        ns++;
        if (sample_ready) nr++;
      end
      if (underrun) nu++;
    end
  endtask

  logic [31:0] dw, ww;
  int          ns, nu, nr;
  logic [31:0] exp_b2b [3] = '{32'h1234_8001, 32'hFFFF_0000, 32'h7FFF_8000};

  initial begin
    rst_n = 1'b0; en = 1'b0; en9 = 1'b0; sample_valid = 1'b0; left = '0; right = '0;
    repeat (3) @(negedge clk);
    chk("rst_bclk", i2s_bclk, 0);
    chk("rst_ws", i2s_ws, 0);
    chk("rst_data", i2s_data, 0);
    chk("rst_ready", sample_ready, 1);
    chk("rst_strobe", frame_strobe, 0);
    chk("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    tick();

    // Single pair queued before enable
    tbl.delete(); tbl.push_back(32'hA5C3_0F01); start_src();
    tick();
    chk("p1_ready_low", sample_ready, 0);
    en = 1'b1;
    next_fall();
    chk("slot0_ws", i2s_ws, 0);
    chk("slot0_data", i2s_data, 0);
    capture_frame(dw, ww, ns, nu, nr);
    chk("f1_data", dw, 32'hA5C3_0F01);
    chk("f1_ws", ww, 32'h0001_FFFE);
    chk("f1_strobe", ns, 1);
    chk("f1_underrun", nu, 0);
    chk("f1_ready_after_load", nr, 1);

    // No new pair: underrun frame
    capture_frame(dw, ww, ns, nu, nr);
    chk("f2_data", dw, F2_EXP);
    chk("f2_ws", ww, 32'h0001_FFFE);
    chk("f2_strobe", ns, 1);
    chk("f2_underrun", nu, 1);

    // Back-to-back pairs with valid held high
    tbl.delete();
    foreach (exp_b2b[k]) tbl.push_back(exp_b2b[k]);
    accepts = 0; ready_bad = 0;
    start_src();
    for (int k = 0; k < 3; k++) begin
      capture_frame(dw, ww, ns, nu, nr);
      chk($sformatf("b2b%0d_data", k), dw, exp_b2b[k]);
      chk($sformatf("b2b%0d_strobe", k), ns, 1);
      chk($sformatf("b2b%0d_underrun", k), nu, 0);
      chk($sformatf("b2b%0d_ready_after_load", k), nr, 1);
    end
    chk("b2b_accepts", accepts, 3);
    chk("b2b_ready_drop", ready_bad, 0);

    // Enable dropped at slot 7, pair queued while idle
    repeat (7) next_fall();
    tick(); tick();
    chk("pre_drop_bclk", i2s_bclk, 1);
    en = 1'b0;
    tick();
    chk("drop_bclk", i2s_bclk, 0);
    chk("drop_ws", i2s_ws, 0);
    chk("drop_data", i2s_data, 0);
    tbl.delete(); tbl.push_back(32'h5A5A_C3C3); start_src();
    tick(); tick();
    chk("idle_queued_ready", sample_ready, 0);
    chk("idle_bclk", i2s_bclk, 0);
    en = 1'b1;
    tick();
    chk("en_rise_c1_bclk", i2s_bclk, 0);
    tick();
    chk("en_rise_c2_bclk", i2s_bclk, 1);
    next_fall();
    capture_frame(dw, ww, ns, nu, nr);
    chk("reen_data", dw, 32'h5A5A_C3C3);
    chk("reen_strobe", ns, 1);
    chk("reen_underrun", nu, 0);

    // Async reset mid-frame with a full holding register
    tbl.delete(); tbl.push_back(32'hDEAD_BEEF); start_src();
    tick(); tick();
    chk("pre_rst_bclk", i2s_bclk, 1);
    chk("pre_rst_data", i2s_data, 1);
    chk("pre_rst_ready", sample_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_bclk", i2s_bclk, 0);
    chk("async_rst_data", i2s_data, 0);
    chk("async_rst_ws", i2s_ws, 0);
    chk("async_rst_ready", sample_ready, 1);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", sample_ready, 1);
    en = 1'b1;
    next_fall();
    capture_frame(dw, ww, ns, nu, nr);
    chk("post_rst_data", dw, 32'h0000_0000);
    chk("post_rst_strobe", ns, 1);
    chk("post_rst_underrun", nu, 1);

    // BCLK_HALF=9 timing: 18-cycle BCLK, 576-cycle frame over 3 frames
    en = 1'b0;
    en9 = 1'b1;
    begin
      bit   found;
      int   t, last_rise, rises, bad, cyc;
      logic prevb;
      found = 1'b0;
      for (int c = 0; c < 2000; c++) begin
        tick();
        if (strobe9) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) chk("bh9_strobe_timeout", {31'b0, found}, 32'd1);
      t = 0; last_rise = -1; rises = 0; bad = 0;
      prevb = bclk9;
      for (int f = 0; f < 3; f++) begin
        cyc = 0;
        do begin
          tick();
          t++; cyc++;
          if (bclk9 && !prevb) begin
            rises++;
            if (last_rise >= 0 && (t - last_rise) != 18) bad++;
            last_rise = t;
          end
          prevb = bclk9;
        end while (!strobe9 && cyc < 2000);
        chk($sformatf("bh9_frame%0d_cycles", f), cyc, 576);
      end
      chk("bh9_rises", rises, 96);
      chk("bh9_bad_periods", bad, 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/i2s_audio_tx.md
Name: i2s_audio_tx

Overview:
- I2S transmitter (master) that drives bit clock, word select and serial data to an external DAC or wavetable daughterboard.
- It is the transmit counterpart of the existing clkbd/wsbd/dabd I2S input path.
- It accepts 16-bit stereo sample pairs from the audio mixer over a valid/ready handshake, double-buffers them, and serialises one pair per 32-BCLK frame in standard Philips I2S format.
- It sits beside the audio output block, in the sysclk domain.

Parameters:
- BCLK_HALF, 9: sysclk cycles per BCLK half-period (BCLK = clk/(2*BCLK_HALF)); must be >= 2.
- SAMPLE_W, 16: bits per channel; frame length is 2*SAMPLE_W slots.

Ports:
- clk  in  1  system clock (sysclk, 28 MHz)
- rst_n  in  1  asynchronous active-low reset
- en  in  1  transmitter enable; low = idle
- left  in  SAMPLE_W  left sample, two's complement
- right  in  SAMPLE_W  right sample, two's complement
- sample_valid  in  1  left/right pair present
- sample_ready  out  1  holding register empty
- i2s_bclk  out  1  bit clock
- i2s_ws  out  1  word select (0 = left)
- i2s_data  out  1  serial data, MSB first
- frame_strobe  out  1  one-cycle pulse when a new frame is loaded
- underrun  out  1  one-cycle pulse when a frame is loaded with no new sample

Behaviour:
- Reset values: all outputs 0 except sample_ready = 1. Holding register empty. Shift register 0. Prescaler 0. Slot counter = 2*SAMPLE_W-1.
- Prescaler:
  - Counts 0..BCLK_HALF-1 while en = 1.
  - At the terminal count it wraps and i2s_bclk toggles.
  - A 1→0 toggle is a "fall event".
- Fall events:
  - Slot counter advances mod 2*SAMPLE_W.
  - i2s_ws, i2s_data and the shifter update in the same clk edge as i2s_bclk falls.
  - All outputs are registered.
- Slot mapping (N = SAMPLE_W):
  - i2s_ws = 1 for slots N..2N-1, else 0.
  - i2s_data in slot s carries frame bit (s-1) mod 2N, where frame = {left, right}, bit 0 = left MSB.
  - Slot 0 therefore outputs the previous frame's right LSB. This gives the one-BCLK WS-to-MSB delay.
- Frame load occurs at the fall event entering slot 1:
  - If the holding register is full: shifter ← holding, holding empties, frame_strobe pulses.
  - If it is empty: the shifter reloads the previous frame's pair, and frame_strobe and underrun both pulse.
- Handshake:
  - sample_ready = holding empty.
  - A transfer occurs when sample_valid && sample_ready; the holding register then fills on that edge.
  - The source may hold sample_valid high indefinitely.
  - The load empties the holding register; sample_ready rises the following cycle. No same-cycle load-and-accept bypass.
  - left/right are sampled only on the transfer edge.
- en = 0:
  - On the next clk edge: prescaler 0, slot counter 2N-1, i2s_bclk/i2s_ws/i2s_data = 0, no pulses.
  - Holding register and handshake stay active: one pair can be queued while disabled.
- en rising: the first bclk rise occurs BCLK_HALF cycles later, and the first fall event enters slot 0.
- en dropped mid-frame: the frame is abandoned. Re-enable starts a clean frame, and the queued pair is loaded at slot 1.
- Asynchronous reset mid-frame: immediate return to reset values and the holding contents are discarded.
- Simultaneous transfer and load in one cycle cannot occur, because a load requires holding full, which forces sample_ready low.

Optional Feature:
- Macro: I2S_TX_UNDERRUN_MUTE_EN.
- Defined: on underrun the shifter loads all zeros (silence) instead of repeating the previous pair; underrun still pulses.
- Undefined: the previous pair repeats, as described above.

Decomposition:
- Shared package/header holds:
  - default SAMPLE_W
  - default BCLK_HALF for 28 MHz (9 → 1.556 MHz BCLK, 48.6 kHz fs)
  - frame length localparam 2*SAMPLE_W
- One natural sub-module: i2s_bclk_gen (prescaler + bclk toggle + fall-event strobe + enable clearing).
- Top holds the holding register, shifter and slot counter.

Test Plan:
- BCLK_HALF=2, reset released, en=1, one pair L=16'hA5C3 R=16'h0F01 → slots 1–16 carry A5C3 MSB first; slots 17–32 carry 0F01; ws=1 exactly on slots 16–31; frame_strobe once; no underrun.
- Back-to-back pairs with sample_valid held high → sample_ready drops after each accept and rises one cycle after each slot-1 load; consecutive frames carry consecutive pairs without gaps.
- No second pair supplied → the second frame repeats the first pair and underrun pulses once. With I2S_TX_UNDERRUN_MUTE_EN defined, the second frame is all zero data.
- en dropped at slot 7 → next clk edge bclk/ws/data = 0. A pair is queued while disabled. After en rises, the first bclk rise occurs 2 cycles later, and the queued pair appears starting at slot 1.
- rst_n asserted mid-frame with a full holding register → outputs 0 asynchronously, sample_ready = 1 after release, and the discarded pair never appears.
- BCLK_HALF=9 → the bclk period is exactly 18 clk cycles and the frame is exactly 576 clk cycles, checked over 3 frames.
